// File: rtl/nes_poll_controller.sv
// NES gamepad poll sequencer: owns the pad latch/clock timing, samples the
// serial data line through a two-flop synchronizer and publishes one
// active-high button byte per poll. Polls come from an explicit request or
// from the internal periodic scheduler.
module nes_poll_controller #(
    parameter int LATCH_CYCLES = 2,
    parameter int HALF_PERIOD  = 2,
    parameter int POLL_PERIOD  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       autoPoll,
    input  logic       nesData,
    output logic       nesLatch,
    output logic       nesClk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int IW        = $clog2(POLL_PERIOD);

    localparam logic [PW-1:0] LATCH_LOAD = PW'(LATCH_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] TICK_LAST  = IW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t          stateReg;
    state_t          stateNext;
    logic [1:0]      syncReg;
    logic            dataSync;
    logic [IW-1:0]   intervalCnt;
    logic            tick;
    logic [PW-1:0]   phaseCnt;
    logic            phaseDone;
    logic [2:0]      bitIdx;
    logic [7:0]      shiftReg;

    assign dataSync  = syncReg[1];
    assign phaseDone = (phaseCnt == '0);
    assign tick      = autoPoll && (intervalCnt == TICK_LAST);

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncReg <= 2'b00;
        end else begin
            syncReg <= {syncReg[0], nesData};
        end
    end

    // Periodic scheduler: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset || !autoPoll) begin
            intervalCnt <= '0;
        end else if (intervalCnt == TICK_LAST) begin
            intervalCnt <= '0;
        end else begin
            intervalCnt <= intervalCnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        stateNext = stateReg;
        nesLatch  = 1'b0;
        nesClk    = 1'b0;
        valid     = 1'b0;
        busy      = 1'b1;
        case (stateReg)
            IDLE: begin
                busy = 1'b0;
                if (start || tick) begin
                    stateNext = LATCH;
                end
            end
            LATCH: begin
                nesLatch = 1'b1;
                if (phaseDone) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                stateNext = CLK_HI;
            end
            CLK_HI: begin
                nesClk = 1'b1;
                if (phaseDone) begin
                    stateNext = CLK_LO;
                end
            end
            CLK_LO: begin
                if (phaseDone) begin
                    stateNext = (bitIdx == 3'd7) ? DONE : SAMPLE;
                end
            end
            DONE: begin
                valid     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Phase counter: loaded on entry to each timed state, counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            phaseCnt <= '0;
        end else if (stateReg == IDLE && stateNext == LATCH) begin
            phaseCnt <= LATCH_LOAD;
        end else if (stateReg == SAMPLE || (stateReg == CLK_HI && phaseDone)) begin
            phaseCnt <= HALF_LOAD;
        end else if (!phaseDone) begin
            phaseCnt <= phaseCnt - 1'b1;
        end
    end

    // Bit index: cleared during the latch, advanced at the end of each low phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitIdx <= 3'd0;
        end else if (stateReg == LATCH) begin
            bitIdx <= 3'd0;
        end else if (stateReg == CLK_LO && phaseDone && bitIdx != 3'd7) begin
            bitIdx <= bitIdx + 3'd1;
        end
    end

    // Capture each synchronized sample, inverted so pressed reads as 1; A lands in bit 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg <= 8'h00;
        end else if (stateReg == SAMPLE) begin
            shiftReg[3'd7 - bitIdx] <= ~dataSync;
        end
    end

    // Publish on entry to DONE so the new byte is already visible while valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons <= 8'h00;
        end else if (stateReg == CLK_LO && stateNext == DONE) begin
            buttons <= shiftReg;
        end
    end

endmodule

// File: tb/tb_nes_poll_controller.sv
// Bench for nes_poll_controller: pad model, poll-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_nes_poll_controller;

    localparam int L        = 2;
    localparam int H        = 2;
    localparam int P        = 100;
    localparam int BIT_CYC  = 1 + 2 * H;
    localparam int DONE_OFF = L + 8 * BIT_CYC;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       autoPoll;
    logic       nesData;
    logic       nesLatch;
    logic       nesClk;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    nes_poll_controller #(
        .LATCH_CYCLES(L),
        .HALF_PERIOD (H),
        .POLL_PERIOD (P)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .autoPoll(autoPoll),
        .nesData (nesData),
        .nesLatch(nesLatch),
        .nesClk  (nesClk),
        .buttons (buttons),
        .valid   (valid),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pad model: reloads on latch, shifts on each nesClk rise, drives low for pressed.
    logic [7:0] padPressed = 8'h00;
    int         padIdx     = 8;
    always @(posedge nesLatch) padIdx <= 0;
    always @(posedge nesClk) if (nesLatch !== 1'b1) padIdx <= padIdx + 1;
    assign nesData = (padIdx < 8) ? ~padPressed[3'(7 - padIdx)] : 1'b0;

    // Reference model: a poll is a fixed timeline of offsets from its first latch cycle.
    int         cyc      = 0;
    bit         checkEn  = 1'b0;
    bit         mInPoll  = 1'b0;
    int         mOff     = 0;
    int         runLen   = 0;
    logic [7:0] mButtons = 8'h00;

    always @(posedge clk) begin
        bit tickNow;
        cyc++;
        if (reset) begin
            mInPoll  = 1'b0;
            mOff     = 0;
            runLen   = 0;
            mButtons = 8'h00;
            checkEn  = 1'b1;
        end else begin
            tickNow = autoPoll && ((runLen % P) == P - 1);
            runLen  = autoPoll ? runLen + 1 : 0;
            if (mInPoll) begin
                if (mOff == DONE_OFF) mInPoll = 1'b0;
                else mOff++;
            end else if (start || tickNow) begin
                mInPoll = 1'b1;
                mOff    = 0;
            end
            if (mInPoll && mOff == DONE_OFF) mButtons = padPressed;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int  o;
        bit  eLatch, eClk, eValid, eBusy;
        if (checkEn) begin
            o      = mOff - L;
            eLatch = mInPoll && (mOff < L);
            eClk   = mInPoll && (mOff >= L) && (mOff < DONE_OFF)
                     && ((o % BIT_CYC) >= 1) && ((o % BIT_CYC) <= H);
            eValid = mInPoll && (mOff == DONE_OFF);
            eBusy  = mInPoll;
            check("model_nesLatch", nesLatch, eLatch);
            check("model_nesClk", nesClk, eClk);
            check("model_valid", valid, eValid);
            check("model_busy", busy, eBusy);
            check("model_buttons", buttons, mButtons);
        end
    end

    // Event monitors used by the directed checks.
    int   validCnt   = 0;
    int   latchRises = 0;
    int   clkRises   = 0;
    int   validCycles[$];
    logic prevLatch  = 1'b0;
    logic prevClk    = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            validCnt++;
            validCycles.push_back(cyc);
        end
        if (nesLatch === 1'b1 && prevLatch !== 1'b1) latchRises++;
        if (nesClk === 1'b1 && prevClk !== 1'b1) clkRises++;
        prevLatch = nesLatch;
        prevClk   = nesClk;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) step();
    endtask

    task automatic validAt(input string name, input int c);
        bit found = 1'b0;
        foreach (validCycles[i]) if (validCycles[i] == c) found = 1'b1;
        check(name, found, 1'b1);
    endtask

    // One requested poll with the pad holding pat; expBtn is the hand-derived result.
    task automatic doPoll(input string name, input logic [7:0] pat, input logic [7:0] expBtn);
        int c0, v0, k0;
        padPressed = pat;
        c0 = cyc;
        v0 = validCnt;
        k0 = clkRises;
        start = 1'b1;
        step();
        start = 1'b0;
        waitUntil(c0 + 43);
        check({name, "_valid43"}, valid, 1'b1);
        check({name, "_buttons"}, buttons, expBtn);
        step();
        check({name, "_busy44"}, busy, 1'b0);
        check({name, "_hold"}, buttons, expBtn);
        check({name, "_nvalid"}, validCnt - v0, 1);
        check({name, "_nclk"}, clkRises - k0, 8);
    endtask

    initial begin
        int c0, v0, r0, a0;
        reset    = 1'b1;
        start    = 1'b0;
        autoPoll = 1'b0;
        step(2);
        reset = 1'b0;
        check("reset_latch", nesLatch, 1'b0);
        check("reset_clk", nesClk, 1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_buttons", buttons, 8'h00);
        step(3);

        // A and Start pressed: detailed timing of the first poll.
        padPressed = 8'h90;
        c0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_latch_c1", nesLatch, 1'b1);
        step();
        check("t1_latch_c2", nesLatch, 1'b1);
        step();
        check("t1_latch_c3", nesLatch, 1'b0);
        step();
        check("t1_clk_c4", nesClk, 1'b1);
        step();
        check("t1_clk_c5", nesClk, 1'b1);
        step();
        check("t1_clk_c6", nesClk, 1'b0);
        waitUntil(c0 + 43);
        check("t1_valid43", valid, 1'b1);
        check("t1_buttons", buttons, 8'h90);
        step();
        check("t1_busy44", busy, 1'b0);
        check("t1_clkpulses", clkRises, 8);
        step(3);

        doPoll("none", 8'h00, 8'h00);
        step(2);
        doPoll("all", 8'hFF, 8'hFF);
        step(2);
        doPoll("dirs", 8'h0F, 8'h0F);
        step(2);

        // Periodic scheduler: first tick 99 cycles after enabling, then every 100.
        padPressed = 8'h0F;
        a0 = cyc;
        autoPoll = 1'b1;
        waitUntil(a0 + 343);
        validAt("auto_v1", a0 + 142);
        validAt("auto_v2", a0 + 242);
        validAt("auto_v3", a0 + 342);
        check("auto_buttons", buttons, 8'h0F);
        autoPoll = 1'b0;
        r0 = latchRises;
        step(250);
        check("auto_off_nolatch", latchRises - r0, 0);

        // start during a poll is dropped.
        c0 = cyc;
        v0 = validCnt;
        start = 1'b1;
        step();
        start = 1'b0;
        waitUntil(c0 + 10);
        start = 1'b1;
        step();
        start = 1'b0;
        waitUntil(c0 + 100);
        check("busy_drop_nvalid", validCnt - v0, 1);
        validAt("busy_drop_v", c0 + 43);

        // start held: back-to-back polls, one idle cycle between them.
        c0 = cyc;
        v0 = validCnt;
        start = 1'b1;
        waitUntil(c0 + 44);
        check("held_idle44", busy, 1'b0);
        step();
        check("held_busy45", busy, 1'b1);
        waitUntil(c0 + 200);
        start = 1'b0;
        waitUntil(c0 + 225);
        for (int k = 0; k < 5; k++) validAt("held_spacing", c0 + 43 + 44 * k);
        check("held_nvalid", validCnt - v0, 5);

        // Simultaneous start and tick yield a single poll.
        a0 = cyc;
        v0 = validCnt;
        r0 = latchRises;
        autoPoll = 1'b1;
        waitUntil(a0 + 99);
        start = 1'b1;
        step();
        start = 1'b0;
        waitUntil(a0 + 143);
        autoPoll = 1'b0;
        waitUntil(a0 + 250);
        check("both_nvalid", validCnt - v0, 1);
        check("both_nlatch", latchRises - r0, 1);
        validAt("both_v", a0 + 142);

        // Reset during CLK_HI of bit 4 aborts cleanly.
        doPoll("pre_reset", 8'h90, 8'h90);
        step(2);
        c0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        waitUntil(c0 + 24);
        check("rst_in_clkhi", nesClk, 1'b1);
        check("rst_prev_buttons", buttons, 8'h90);
        v0 = validCnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_latch", nesLatch, 1'b0);
        check("rst_clk", nesClk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_buttons", buttons, 8'h00);
        step(40);
        check("rst_novalid", validCnt - v0, 0);
        doPoll("post_reset", 8'h90, 8'h90);
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
